// File: rtl/weight_fifo_drain_control_pkg.sv
// Shared definitions for the weight FIFO drain controller: FSM state
// encoding and the width of the diagonal-skew cycle counter.
package weight_fifo_drain_control_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } state_e;

   localparam int DEF_ROWS = 16;
   localparam int DEF_COLS = 16;

   // Counter must hold C+R (up to rows+cols-2) without wrapping, plus headroom
   // so that c+R and C+R sums never overflow at full array size.
   function automatic int cnt_width(input int rows, input int cols);
      return $clog2(rows + cols) + 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_ROWS, DEF_COLS);

endpackage

// File: rtl/weight_fifo_drain_control.sv
// Weight FIFO drain controller: pops the per-column weight FIFOs into the
// systolic array's shift chain in a diagonal skew (column c during cycles
// c..c+R of the drain), then issues a single weight_load pulse.
module weight_fifo_drain_control
   import weight_fifo_drain_control_pkg::*;
#(
   parameter int SYS_ARR_ROWS = DEF_ROWS,
   parameter int SYS_ARR_COLS = DEF_COLS
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   output logic                            done,
   input  logic [$clog2(SYS_ARR_ROWS)-1:0] num_row,
   input  logic [$clog2(SYS_ARR_COLS)-1:0] num_col,
   input  logic [SYS_ARR_COLS-1:0]         fifo_empty,
   output logic [SYS_ARR_COLS-1:0]         fifo_pop,
   output logic                            weight_load,
   output logic                            underflow
);

   localparam int RW = $clog2(SYS_ARR_ROWS);
   localparam int CW = $clog2(SYS_ARR_COLS);
   localparam int TW = cnt_width(SYS_ARR_ROWS, SYS_ARR_COLS);

   state_e          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic            underflow_q, underflow_d;

   // Latched sizes widened to counter width so sums never wrap.
   logic [TW-1:0]   row_ext;
   logic [TW-1:0]   col_ext;
   logic [SYS_ARR_COLS-1:0] win;

   assign row_ext = TW'(row_q);
   assign col_ext = TW'(col_q);

   // Per-column skew window: column active, and R >= t-c >= 0.
   // Differences are taken one bit wider so the top bit acts as a sign.
   for (genvar gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_col
      localparam logic [TW-1:0] COL_IDX = TW'(gi);
      logic [TW:0] col_diff;
      logic [TW:0] t_diff;

      assign col_diff = {1'b0, col_ext} - {1'b0, COL_IDX};
      assign t_diff   = {1'b0, t_q} - {1'b0, COL_IDX};
      assign win[gi]  = (state_q == DRAIN) && !col_diff[TW] && !t_diff[TW]
                        && (t_diff[TW-1:0] <= row_ext);
      assign fifo_pop[gi] = win[gi] & ~fifo_empty[gi];
   end

   assign weight_load = (state_q == LOAD);
   assign done        = (state_q == IDLE);
   assign underflow   = underflow_q;

   // Next-state logic: accept start in IDLE, step the skew counter in DRAIN,
   // flag any pop that was due on an empty FIFO.
   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      row_d       = row_q;
      col_d       = col_q;
      underflow_d = underflow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               row_d       = num_row;
               col_d       = num_col;
               underflow_d = 1'b0;
               t_d         = '0;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            if (|(win & fifo_empty)) begin
               underflow_d = 1'b1;
            end
            if (t_q == col_ext + row_ext) begin
               t_d     = '0;
               state_d = LOAD;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         LOAD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   // State register with synchronous active-low reset overriding everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         t_q         <= '0;
         row_q       <= '0;
         col_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         row_q       <= row_d;
         col_q       <= col_d;
         underflow_q <= underflow_d;
      end
   end

endmodule
